// File: rtl/silu_pkg.sv
// Shared constants and state type for the SiLU vector driver and its lane unpacker.
package silu_pkg;

  localparam int unsigned          FP16_W    = 16;
  localparam logic [FP16_W-1:0]    FP16_ZERO = 16'h0000;

  typedef enum logic [1:0] {
    FILL,
    START,
    WAIT,
    DRAIN
  } silu_drv_state_t;

endpackage

// File: rtl/silu_lane_unpacker.sv
// Holds a captured engine product and replays its first n lanes, lane 0 (MSBs) first,
// on a valid/ready stream.
module silu_lane_unpacker
  import silu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FP16_W,
  parameter int unsigned SIZE       = 4,
  parameter int unsigned CW         = $clog2(SIZE + 1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_load,
  input  logic [SIZE*DATA_WIDTH-1:0] i_buf,
  input  logic [CW-1:0]              i_n_valid,
  input  logic                       i_last_flag,
  output logic [DATA_WIDTH-1:0]      o_data,
  output logic                       o_valid,
  output logic                       o_last,
  input  logic                       i_ready,
  output logic                       o_done
);

  logic [SIZE*DATA_WIDTH-1:0] r_buf;
  logic [CW-1:0]              r_idx;
  logic [CW-1:0]              r_n;
  logic                       r_last;
  logic                       r_active;
  logic                       w_fire;
  logic                       w_final;

  assign w_fire  = r_active && i_ready;
  assign w_final = (r_idx == (r_n - CW'(1)));

  always_ff @(posedge clk) begin
    if (reset) begin
      r_buf    <= '0;
      r_idx    <= '0;
      r_n      <= '0;
      r_last   <= 1'b0;
      r_active <= 1'b0;
    end else if (i_load) begin
      r_buf    <= i_buf;
      r_idx    <= '0;
      r_n      <= i_n_valid;
      r_last   <= i_last_flag;
      r_active <= 1'b1;
    end else if (w_fire) begin
      if (w_final) begin
        r_active <= 1'b0;
        r_idx    <= '0;
      end else begin
        r_idx <= r_idx + CW'(1);
      end
    end
  end

  always_comb begin
    o_data = '0;
    for (int i = 0; i < SIZE; i++) begin
      if (r_idx == CW'(i)) o_data = r_buf[(SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign o_valid = r_active;
  assign o_last  = r_active && r_last && w_final;
  assign o_done  = w_fire && w_final;

endmodule

// File: rtl/silu_vec_driver.sv
// Packs FP16 words into SIZE-lane vectors, starts the SiLU engine, and streams back results.
// Optional watchdog on the engine wait: define SILU_VEC_DRIVER_TIMEOUT_EN.
module silu_vec_driver
  import silu_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = FP16_W,
  parameter int unsigned SIZE       = 4,
  parameter int unsigned TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic                       in_valid,
  input  logic                       in_last,
  output logic                       in_ready,
  output logic [SIZE*DATA_WIDTH-1:0] act_x,
  output logic                       act_start,
  input  logic [SIZE*DATA_WIDTH-1:0] act_product,
  input  logic                       act_finished,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic                       out_valid,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy,
  output logic                       timeout_err
);

  localparam int unsigned    VW       = SIZE * DATA_WIDTH;
  localparam int unsigned    CW       = $clog2(SIZE + 1);
  localparam logic [CW-1:0]  LastLane = CW'(SIZE - 1);

  if (TIMEOUT < 2) begin : g_bad_timeout
    $error("TIMEOUT must be at least 2");
  end

  silu_drv_state_t r_state;
  silu_drv_state_t w_state_next;

  logic [CW-1:0]         r_cnt;
  logic [CW-1:0]         r_n_valid;
  logic [VW-1:0]         r_x;
  logic                  r_last_flag;
  logic                  w_in_ready;
  logic                  w_act_start;
  logic                  w_in_fire;
  logic                  w_close;
  logic                  w_wait_armed;
  logic                  w_capture;
  logic                  w_timeout;
  logic                  w_timeout_err;
  logic                  w_done;
  logic [DATA_WIDTH-1:0] w_out_data;
  logic                  w_out_valid;
  logic                  w_out_last;

  assign w_in_fire = w_in_ready && in_valid;
  assign w_close   = w_in_fire && (in_last || (r_cnt == LastLane));
  assign w_capture = (r_state == WAIT) && w_wait_armed && act_finished;

`ifdef SILU_VEC_DRIVER_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout_err;

  // Counts WAIT cycles already elapsed; zero marks the first WAIT cycle.
  always_ff @(posedge clk) begin
    if (reset || (r_state != WAIT)) begin
      r_wait_cnt <= '0;
    end else begin
      r_wait_cnt <= r_wait_cnt + TW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_timeout_err <= 1'b0;
    end else if (w_timeout) begin
      r_timeout_err <= 1'b1;
    end
  end

  assign w_wait_armed  = (r_wait_cnt != '0);
  assign w_timeout     = (r_state == WAIT) && !w_capture && (r_wait_cnt == TW'(TIMEOUT - 1));
  assign w_timeout_err = r_timeout_err;
`else
  logic r_wait_armed;

  // Low in the first WAIT cycle so a stale Finished is not taken as completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wait_armed <= 1'b0;
    end else begin
      r_wait_armed <= (r_state == WAIT);
    end
  end

  assign w_wait_armed  = r_wait_armed;
  assign w_timeout     = 1'b0;
  assign w_timeout_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= FILL;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      FILL:    if (w_close) w_state_next = START;
      START:   w_state_next = WAIT;
      WAIT:    if (w_capture || w_timeout) w_state_next = DRAIN;
      DRAIN:   if (w_done) w_state_next = FILL;
      default: w_state_next = FILL;
    endcase
  end

  always_comb begin
    w_in_ready  = 1'b0;
    w_act_start = 1'b0;
    unique case (r_state)
      FILL:    w_in_ready  = 1'b1;
      START:   w_act_start = 1'b1;
      default: ;
    endcase
  end

  // Vector is zeroed on drain completion so unfilled lanes of the next vector pad to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt       <= '0;
      r_n_valid   <= '0;
      r_x         <= '0;
      r_last_flag <= 1'b0;
    end else if (w_in_fire) begin
      for (int i = 0; i < SIZE; i++) begin
        if (r_cnt == CW'(i)) r_x[(SIZE-1-i)*DATA_WIDTH +: DATA_WIDTH] <= in_data;
      end
      r_cnt <= r_cnt + CW'(1);
      if (w_close) begin
        r_n_valid   <= r_cnt + CW'(1);
        r_last_flag <= in_last;
      end
    end else if (w_done) begin
      r_cnt <= '0;
      r_x   <= '0;
    end
  end

  silu_lane_unpacker #(
    .DATA_WIDTH (DATA_WIDTH),
    .SIZE       (SIZE),
    .CW         (CW)
  ) u_unpacker (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_capture || w_timeout),
    .i_buf       (w_capture ? act_product : {VW{1'b0}}),
    .i_n_valid   (r_n_valid),
    .i_last_flag (r_last_flag),
    .o_data      (w_out_data),
    .o_valid     (w_out_valid),
    .o_last      (w_out_last),
    .i_ready     (out_ready),
    .o_done      (w_done)
  );

  assign in_ready    = w_in_ready && !reset;
  assign act_start   = w_act_start && !reset;
  assign act_x       = reset ? {VW{1'b0}} : r_x;
  assign out_data    = reset ? {DATA_WIDTH{1'b0}} : w_out_data;
  assign out_valid   = w_out_valid && !reset;
  assign out_last    = w_out_last && !reset;
  assign busy        = !reset && ((r_state != FILL) || (r_cnt != '0));
  assign timeout_err = w_timeout_err && !reset;

endmodule

// File: tb/tb_silu_vec_driver.sv
// Randomized bench for silu_vec_driver with an engine stub (product = ~x after 12 cycles)
// and a queue-based model of vector packing and result replay.
`timescale 1ns/1ps
module tb_silu_vec_driver;

  localparam int DW = 16;
  localparam int SZ = 4;
  localparam int VW = DW * SZ;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          in_last = 1'b0;
  logic          in_ready;
  logic [VW-1:0] act_x;
  logic          act_start;
  logic [VW-1:0] act_product;
  logic          act_finished;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_last;
  logic          out_ready;
  logic          busy;
  logic          timeout_err;

  always #5 clk = ~clk;

  silu_vec_driver #(.DATA_WIDTH(DW), .SIZE(SZ), .TIMEOUT(64)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .act_x        (act_x),
    .act_start    (act_start),
    .act_product  (act_product),
    .act_finished (act_finished),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_last     (out_last),
    .out_ready    (out_ready),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW-1:0] exp_out[$];
  logic          exp_last[$];
  logic [VW-1:0] exp_x[$];
  logic [DW:0]   lit_out[$];
  logic [VW-1:0] lit_x[$];
  logic [DW-1:0] cur[$];

  int   stub_mode = 0;   // 0 normal, 1 stale Finished at start, 2 never finishes
  logic stub_abort = 1'b0;
  logic rand_ready = 1'b0;
  int   bp_cnt = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endtask

  task automatic fail(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: bound expired or unexpected event", name);
  endtask

  // Behavioural model: words group into vectors of SZ or until in_last; lane 0 at the MSBs.
  task automatic model_push(input logic [DW-1:0] d, input logic l);
    logic [VW-1:0] x;
    cur.push_back(d);
    if (cur.size() == SZ || l) begin
      x = '0;
      for (int i = 0; i < cur.size(); i++) x[(SZ-1-i)*DW +: DW] = cur[i];
      exp_x.push_back(x);
      for (int i = 0; i < cur.size(); i++) begin
        exp_out.push_back(stub_mode == 2 ? 16'h0000 : ~cur[i]);
        exp_last.push_back(l && (i == cur.size() - 1));
      end
      cur.delete();
    end
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic l);
    int t;
    t = 0;
    in_data  = d;
    in_last  = l;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && t < 300) begin
      t++;
      @(negedge clk);
    end
    if (!in_ready) begin
      fail("in_handshake_timeout");
      @(posedge clk); #1;
      in_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      model_push(d, l);
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    @(negedge clk);
    while ((exp_out.size() != 0 || busy) && t < 400) begin
      t++;
      @(negedge clk);
    end
    if (exp_out.size() != 0 || busy) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  // Engine stub.
  initial begin
    logic [VW-1:0] xs;
    act_finished = 1'b0;
    act_product  = '0;
    forever begin
      @(posedge clk); #1;
      if (act_start) begin
        xs = act_x;
        if (stub_mode == 1) begin
          act_finished = 1'b1;
          act_product  = {SZ{16'h1111}};
        end
        for (int k = 1; k <= 12 && !stub_abort; k++) begin
          @(posedge clk); #1;
          if (k == 2) act_finished = 1'b0;
        end
        if (stub_mode != 2 && !stub_abort) begin
          act_finished = 1'b1;
          act_product  = ~xs;
          @(posedge clk); #1;
        end
        act_finished = 1'b0;
      end
    end
  end

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (bp_cnt > 0) begin
        out_ready = 1'b0;
        bp_cnt--;
      end else begin
        out_ready = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
    end
  end

  // Compare process.
  initial begin
    logic          pv, pr, pl, lat_run;
    logic [DW-1:0] pd;
    int            lat;
    pv = 1'b0; pr = 1'b0; pl = 1'b0; pd = '0; lat_run = 1'b0; lat = 0;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_act_x", act_x, 64'h0);
        check("reset_ctrl", {act_start, in_ready, out_valid, out_last, busy, timeout_err,
                             out_data}, 64'h0);
        pv = 1'b0;
        lat_run = 1'b0;
      end else begin
        if (pv && !pr) check("out_hold", {out_valid, out_last, out_data}, {1'b1, pl, pd});
        if (act_start) begin
          if (exp_x.size() == 0) fail("unexpected_start");
          else check("act_x", act_x, exp_x.pop_front());
          if (lit_x.size() != 0) check("act_x_literal", act_x, lit_x.pop_front());
          check("start_status", {busy, in_ready}, 64'h2);
          lat_run = 1'b1;
          lat = 0;
        end else if (lat_run) begin
          lat++;
          if (stub_mode == 2 && !out_valid && timeout_err) fail("timeout_err_early");
          if (out_valid) begin
            lat_run = 1'b0;
            check("first_out_latency", lat, (stub_mode == 2) ? 65 : 13);
            check("timeout_err", timeout_err, (stub_mode == 2) ? 1 : 0);
          end
        end
        if (out_valid && out_ready) begin
          if (exp_out.size() == 0) begin
            fail("unexpected_out");
          end else begin
            check("out_data", out_data, exp_out.pop_front());
            check("out_last", out_last, exp_last.pop_front());
          end
          if (lit_out.size() != 0) check("out_literal", {out_last, out_data}, lit_out.pop_front());
        end
        pv = out_valid; pr = out_ready; pd = out_data; pl = out_last;
      end
    end
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("idle_after_reset", {busy, in_ready, out_valid, act_start}, 64'h4);

    // Full vector with literal expectations.
    lit_x.push_back(64'h40003C009BDC232F);
    lit_out.push_back({1'b0, 16'hBFFF});
    lit_out.push_back({1'b0, 16'hC3FF});
    lit_out.push_back({1'b0, 16'h6423});
    lit_out.push_back({1'b0, 16'hDCD0});
    send_word(16'h4000, 1'b0);
    send_word(16'h3C00, 1'b0);
    send_word(16'h9BDC, 1'b0);
    send_word(16'h232F, 1'b0);
    wait_drain();

    // Partial vector closed by in_last.
    lit_x.push_back(64'h85430B4300000000);
    lit_out.push_back({1'b0, 16'h7ABC});
    lit_out.push_back({1'b1, 16'hF4BC});
    send_word(16'h8543, 1'b0);
    send_word(16'h0B43, 1'b1);
    wait_drain();
    check("literals_consumed", lit_out.size() + lit_x.size(), 0);

    // Backpressure mid-drain.
    for (int i = 0; i < SZ; i++) send_word(16'($urandom), i == SZ - 1);
    t = 0;
    @(negedge clk);
    while (!(out_valid && out_ready) && t < 100) begin
      t++;
      @(negedge clk);
    end
    if (!(out_valid && out_ready)) fail("bp_first_handshake");
    bp_cnt = 5;
    @(posedge clk); #1;
    wait_drain();

    // Stale Finished held through START and first WAIT cycle.
    stub_mode = 1;
    for (int i = 0; i < SZ; i++) send_word(16'($urandom), 1'b0);
    wait_drain();
    stub_mode = 0;

    // Reset mid-WAIT discards the operation.
    for (int i = 0; i < SZ; i++) send_word(16'($urandom), 1'b0);
    repeat (4) @(posedge clk);
    #1;
    stub_abort = 1'b1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    exp_out.delete();
    exp_last.delete();
    exp_x.delete();
    cur.delete();
    reset = 1'b0;
    stub_abort = 1'b0;
    #1;
    check("busy_after_abort", busy, 0);
    for (int i = 0; i < 3; i++) send_word(16'($urandom), i == 2);
    wait_drain();

    // Randomized traffic with random gaps and backpressure.
    rand_ready = 1'b1;
    for (int w = 0; w < 60; w++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send_word(16'($urandom), $urandom_range(0, 5) == 0);
    end
    send_word(16'($urandom), 1'b1);
    wait_drain();
    rand_ready = 1'b0;

`ifdef SILU_VEC_DRIVER_TIMEOUT_EN
    stub_mode = 2;
    for (int i = 0; i < SZ; i++) send_word(16'($urandom), 1'b0);
    wait_drain();
    check("timeout_err_sticky", timeout_err, 1);
`endif

    check("queues_empty", exp_out.size() + exp_x.size() + cur.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
